// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD write bus (lcd_init / lcd_bus_rx).
package lcd_bus_pkg;

    typedef enum logic [1:0] {
        S_BYTE8,
        S_HI,
        S_LO
    } rx_state_e;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    localparam logic [6:0] ADDR_LINE0_END   = 7'h27;
    localparam logic [6:0] ADDR_LINE1_START = 7'h40;
    localparam logic [6:0] ADDR_LINE1_END   = 7'h67;

    // Two-line DDRAM wrap; addresses outside both lines just step modulo 128.
    function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
        if (inc) begin
            if (addr == ADDR_LINE0_END) return ADDR_LINE1_START;
            if (addr == ADDR_LINE1_END) return 7'h00;
            return addr + 7'd1;
        end
        if (addr == ADDR_LINE1_START) return ADDR_LINE0_END;
        if (addr == 7'h00) return ADDR_LINE1_END;
        return addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// 2-FF synchronizers for LCD_E / LCD_D plus E falling-edge detect.
module lcd_bus_sync (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LCD_E,
    input  logic [4:0] LCD_D,
    output logic       e_fall,
    output logic [3:0] nib,
    output logic       rs
);

    logic       e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
    logic [4:0] d1_q, d1_d, d2_q, d2_d, hold_q, hold_d;

    always_comb begin
        e1_d   = LCD_E;
        e2_d   = e1_q;
        e3_d   = e2_q;
        d1_d   = LCD_D;
        d2_d   = d1_q;
        // Keep the data seen in the last synced cycle with E high.
        hold_d = e2_q ? d2_q : hold_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            e1_q   <= 1'b0;
            e2_q   <= 1'b0;
            e3_q   <= 1'b0;
            d1_q   <= 5'h00;
            d2_q   <= 5'h00;
            hold_q <= 5'h00;
        end else begin
            e1_q   <= e1_d;
            e2_q   <= e2_d;
            e3_q   <= e3_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            hold_q <= hold_d;
        end
    end

    assign e_fall = e3_q & ~e2_q;
    assign nib    = hold_q[3:0];
    assign rs     = hold_q[4];

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780 4-bit write-bus receiver with shadow DDRAM address counter.
// Optional strobe timing check enabled by defining LCD_BUS_RX_TIMING_CHECK_EN.
module lcd_bus_rx
    import lcd_bus_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 1850
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] LCD_D,
    input  logic       LCD_E,
    output logic       rx_valid,
    output logic       rx_rs,
    output logic [7:0] rx_byte,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic [6:0] char_addr,
    output logic       clear_pulse,
    output logic       mode4,
    output logic       busy_err
);

    logic       e_fall, s_rs;
    logic [3:0] s_nib;

    lcd_bus_sync u_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .LCD_E  (LCD_E),
        .LCD_D  (LCD_D),
        .e_fall (e_fall),
        .nib    (s_nib),
        .rs     (s_rs)
    );

    rx_state_e  state_q, state_d;
    logic       mode4_q, mode4_d, hi_rs_q, hi_rs_d, id_q, id_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic [6:0] addr_q, addr_d, char_addr_q, char_addr_d;
    logic       rx_valid_q, rx_valid_d, rx_rs_q, rx_rs_d;
    logic       char_valid_q, char_valid_d, clear_q, clear_d;
    logic [7:0] rx_byte_q, rx_byte_d, char_code_q, char_code_d;
    logic       byte_done, b_rs;
    logic [7:0] b;

    always_comb begin
        state_d      = state_q;
        mode4_d      = mode4_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        id_d         = id_q;
        addr_d       = addr_q;
        rx_rs_d      = rx_rs_q;
        rx_byte_d    = rx_byte_q;
        char_code_d  = char_code_q;
        char_addr_d  = char_addr_q;
        rx_valid_d   = 1'b0;
        char_valid_d = 1'b0;
        clear_d      = 1'b0;
        byte_done    = 1'b0;
        b            = 8'h00;
        b_rs         = 1'b0;

        if (e_fall) begin
            case (state_q)
                S_BYTE8: begin
                    byte_done = 1'b1;
                    b         = {s_nib, 4'h0};
                    b_rs      = s_rs;
                    if (!s_rs && s_nib == CMD_FUNC[7:4]) begin
                        state_d = S_HI;
                        mode4_d = 1'b1;
                    end
                end
                S_HI: begin
                    hi_nib_d = s_nib;
                    hi_rs_d  = s_rs;
                    state_d  = S_LO;
                end
                S_LO: begin
                    byte_done = 1'b1;
                    b         = {hi_nib_q, s_nib};
                    b_rs      = hi_rs_q;
                    state_d   = S_HI;
                    // Function Set with DL=1 drops back to 8-bit mode.
                    if (!hi_rs_q && hi_nib_q == 4'h3) begin
                        state_d = S_BYTE8;
                        mode4_d = 1'b0;
                    end
                end
                default: state_d = S_BYTE8;
            endcase
        end

        if (byte_done) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = b;
            rx_rs_d    = b_rs;
            if (b_rs) begin
                char_valid_d = 1'b1;
                char_code_d  = b;
                char_addr_d  = addr_q;
                addr_d       = addr_step(addr_q, id_q);
            end else if ((b & CMD_DDRAM) != 8'h00) begin
                addr_d = b[6:0];
            end else if (b[6:3] != 4'h0) begin
                addr_d = addr_q;
            end else if ((b & CMD_ENTRY) != 8'h00) begin
                id_d = b[1];
            end else if ((b & CMD_HOME) != 8'h00) begin
                addr_d = 7'h00;
            end else if (b == CMD_CLEAR) begin
                addr_d  = 7'h00;
                id_d    = 1'b1;
                clear_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_BYTE8;
            mode4_q      <= 1'b0;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            id_q         <= 1'b1;
            addr_q       <= 7'h00;
            rx_valid_q   <= 1'b0;
            rx_rs_q      <= 1'b0;
            rx_byte_q    <= 8'h00;
            char_valid_q <= 1'b0;
            char_code_q  <= 8'h00;
            char_addr_q  <= 7'h00;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode4_q      <= mode4_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            rx_valid_q   <= rx_valid_d;
            rx_rs_q      <= rx_rs_d;
            rx_byte_q    <= rx_byte_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
            char_addr_q  <= char_addr_d;
            clear_q      <= clear_d;
        end
    end

`ifdef LCD_BUS_RX_TIMING_CHECK_EN
    localparam int unsigned LONG_CYCLES = 82 * BUSY_CYCLES / 2;

    logic [31:0] gap_q, gap_d;
    logic        seen_q, seen_d, long_q, long_d, busy_q, busy_d;

    always_comb begin
        gap_d  = (gap_q == 32'hFFFF_FFFF) ? gap_q : gap_q + 32'd1;
        seen_d = seen_q;
        long_d = long_q;
        busy_d = busy_q;
        if (e_fall) begin
            if (seen_q && gap_q < (long_q ? LONG_CYCLES : BUSY_CYCLES)) busy_d = 1'b1;
            long_d = 1'b0;
        end
        // Gap restarts in the cycle rx_valid is high; Clear/Home need the long wait.
        if (byte_done) begin
            gap_d  = 32'd0;
            seen_d = 1'b1;
            if (!b_rs && b[7:2] == 6'h00 && b[1:0] != 2'b00) long_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_q  <= 32'd0;
            seen_q <= 1'b0;
            long_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            gap_q  <= gap_d;
            seen_q <= seen_d;
            long_q <= long_d;
            busy_q <= busy_d;
        end
    end

    assign busy_err = busy_q;
`else
    logic unused_busy_cycles;
    assign unused_busy_cycles = ^BUSY_CYCLES;
    assign busy_err           = 1'b0;
`endif

    assign rx_valid    = rx_valid_q;
    assign rx_rs       = rx_rs_q;
    assign rx_byte     = rx_byte_q;
    assign char_valid  = char_valid_q;
    assign char_code   = char_code_q;
    assign char_addr   = char_addr_q;
    assign clear_pulse = clear_q;
    assign mode4       = mode4_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed self-checking bench for lcd_bus_rx.
module tb_lcd_bus_rx;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LCD_E = 1'b0;
    logic [4:0] LCD_D = 5'h00;
    logic       rx_valid, rx_rs, char_valid, clear_pulse, mode4, busy_err;
    logic [7:0] rx_byte, char_code;
    logic [6:0] char_addr;

    lcd_bus_rx #(.BUSY_CYCLES(1850)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .LCD_D       (LCD_D),
        .LCD_E       (LCD_E),
        .rx_valid    (rx_valid),
        .rx_rs       (rx_rs),
        .rx_byte     (rx_byte),
        .char_valid  (char_valid),
        .char_code   (char_code),
        .char_addr   (char_addr),
        .clear_pulse (clear_pulse),
        .mode4       (mode4),
        .busy_err    (busy_err)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail = 0;
    logic       ev_seen, ev_rs, ev_cv, ev_clr;
    int         ev_lat;
    logic [7:0] ev_byte, ev_code;
    logic [6:0] ev_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One E pulse; records the first rx_valid seen within 6 cycles of the fall.
    task automatic strobe(input logic rs, input logic [3:0] nib);
        @(negedge CLK);
        LCD_D = {rs, nib};
        LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        LCD_E = 1'b0;
        ev_seen = 1'b0;
        ev_lat  = 0;
        ev_rs   = 1'b0;
        ev_cv   = 1'b0;
        ev_clr  = 1'b0;
        ev_byte = 8'h00;
        ev_code = 8'h00;
        ev_addr = 7'h00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (rx_valid && !ev_seen) begin
                ev_seen = 1'b1;
                ev_lat  = i;
                ev_byte = rx_byte;
                ev_rs   = rx_rs;
                ev_cv   = char_valid;
                ev_code = char_code;
                ev_addr = char_addr;
                ev_clr  = clear_pulse;
            end
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] val);
        strobe(rs, val[7:4]);
        check("hi_nibble_no_pulse", 32'(ev_seen), 32'd0);
        strobe(rs, val[3:0]);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] val, input logic rs);
        check({tag, "_seen"}, 32'(ev_seen), 32'd1);
        check({tag, "_byte"}, 32'(ev_byte), 32'(val));
        check({tag, "_rs"}, 32'(ev_rs), 32'(rs));
    endtask

    task automatic expect_char(input string tag, input logic [7:0] code, input logic [6:0] addr);
        check({tag, "_cv"}, 32'(ev_cv), 32'd1);
        check({tag, "_code"}, 32'(ev_code), 32'(code));
        check({tag, "_addr"}, 32'(ev_addr), 32'(addr));
    endtask

    initial begin
        string s;
        s = "0123456789123456";

        repeat (3) @(negedge CLK);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_mode4", 32'(mode4), 32'd0);
        check("rst_char_addr", 32'(char_addr), 32'd0);
        check("rst_busy_err", 32'(busy_err), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Init: three 8-bit 0x30 writes then 0x20 enters 4-bit mode.
        strobe(1'b0, 4'h3);
        check("latency", 32'(ev_lat), 32'd3);
        expect_rx("init0", 8'h30, 1'b0);
        check("hold_rx_byte", 32'(rx_byte), 32'h30);
        check("init0_mode4", 32'(mode4), 32'd0);
        strobe(1'b0, 4'h3);
        expect_rx("init1", 8'h30, 1'b0);
        strobe(1'b0, 4'h3);
        expect_rx("init2", 8'h30, 1'b0);
        strobe(1'b0, 4'h2);
        expect_rx("init3", 8'h20, 1'b0);
        check("init3_mode4", 32'(mode4), 32'd1);

        send_byte(1'b0, 8'h28);
        expect_rx("func28", 8'h28, 1'b0);
        check("func28_cv", 32'(ev_cv), 32'd0);
        check("func28_mode4", 32'(mode4), 32'd1);
        send_byte(1'b0, 8'h01);
        expect_rx("clear", 8'h01, 1'b0);
        check("clear_pulse", 32'(ev_clr), 32'd1);

        for (int i = 0; i < 16; i++) begin
            send_byte(1'b1, 8'(s[i]));
            expect_char("str", 8'(s[i]), 7'(i));
        end

        // Line-boundary wraps, increment direction.
        send_byte(1'b0, 8'hA7);
        send_byte(1'b1, 8'h78);
        expect_char("x_at_27", 8'h78, 7'h27);
        send_byte(1'b1, 8'h6F);
        expect_char("o_at_40", 8'h6F, 7'h40);
        send_byte(1'b0, 8'hE7);
        send_byte(1'b1, 8'h41);
        expect_char("A_at_67", 8'h41, 7'h67);
        send_byte(1'b1, 8'h42);
        expect_char("B_at_00", 8'h42, 7'h00);

        // Decrement direction.
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h70);
        expect_char("p_at_40", 8'h70, 7'h40);
        send_byte(1'b1, 8'h71);
        expect_char("q_at_27", 8'h71, 7'h27);
        send_byte(1'b0, 8'h02);
        check("home_no_clear", 32'(ev_clr), 32'd0);
        send_byte(1'b1, 8'h68);
        expect_char("h_at_00", 8'h68, 7'h00);
        send_byte(1'b1, 8'h69);
        expect_char("i_at_67", 8'h69, 7'h67);

        // Low-nibble RS mismatch: high-nibble RS wins.
        send_byte(1'b0, 8'h06);
        strobe(1'b1, 4'h4);
        strobe(1'b0, 4'h1);
        expect_rx("rs_mix", 8'h41, 1'b1);
        expect_char("rs_mix", 8'h41, 7'h66);

        send_byte(1'b0, 8'h33);
        expect_rx("func33", 8'h33, 1'b0);
        check("func33_mode4", 32'(mode4), 32'd0);
        strobe(1'b0, 4'h2);
        check("reenter_mode4", 32'(mode4), 32'd1);
        strobe(1'b0, 4'h4);
        check("held_hi_no_pulse", 32'(ev_seen), 32'd0);

        // Reset with a high nibble held.
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("midrst_mode4", 32'(mode4), 32'd0);
        check("midrst_char_addr", 32'(char_addr), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        strobe(1'b0, 4'h3);
        check("post_rst_latency", 32'(ev_lat), 32'd3);
        expect_rx("post_rst", 8'h30, 1'b0);
        check("post_rst_mode4", 32'(mode4), 32'd0);

        // Back-to-back 8-bit data writes, far closer than BUSY_CYCLES.
        strobe(1'b1, 4'h4);
        expect_char("fast0", 8'h40, 7'h00);
        strobe(1'b1, 4'h5);
        expect_char("fast1", 8'h50, 7'h01);
        repeat (20) @(negedge CLK);
`ifdef LCD_BUS_RX_TIMING_CHECK_EN
        check("busy_err_set", 32'(busy_err), 32'd1);
        repeat (50) @(negedge CLK);
        check("busy_err_sticky", 32'(busy_err), 32'd1);
`else
        check("busy_err_tied", 32'(busy_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
